// File: rtl/router_sta_pkg.sv
// Shared definitions for the XY route-computation stage: direction codes, address fields,
// and the positional port-existence helper used when ROUTER_STA_CHECK_EN is defined.
package router_sta_pkg;

    localparam int ADDR_W = 3;
    localparam int X_MSB  = 1;
    localparam int X_LSB  = 0;
    localparam int Y_BIT  = 2;

    typedef logic [2:0] port_t;

    localparam port_t PORT_LOCAL = 3'd0;
    localparam port_t PORT_EAST  = 3'd1;
    localparam port_t PORT_WEST  = 3'd2;
    localparam port_t PORT_VERT  = 3'd3;
    localparam port_t PORT_NONE  = 3'd7;

    // True when a router of this flavour may sit in column x and owns a physical port for dir.
    function automatic logic port_exists(input int num_ports, input logic [1:0] x,
                                         input port_t dir);
        logic pos_ok;
        logic dir_ok;
        if (num_ports == 3)
            pos_ok = (x == 2'd0) || (x == 2'd3);
        else if (num_ports == 4)
            pos_ok = (x == 2'd1) || (x == 2'd2);
        else
            pos_ok = 1'b0;
        case (dir)
            PORT_LOCAL, PORT_VERT: dir_ok = 1'b1;
            PORT_EAST:             dir_ok = (x != 2'd3);
            PORT_WEST:             dir_ok = (x != 2'd0);
            default:               dir_ok = 1'b0;
        endcase
        return pos_ok && dir_ok;
    endfunction

endpackage

// File: rtl/router_sta_3port.sv
// Corner-router (columns 0/3) flavour of the XY route stage.
module router_sta_3port
    import router_sta_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] router_add,
    input  logic [ADDR_W-1:0] dst,
    output logic [2:0]        port
);

    router_sta #(.NUM_PORTS(3)) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .router_add (router_add),
        .dst        (dst),
        .port       (port)
    );

endmodule

// File: rtl/router_sta_4port.sv
// Middle-router (columns 1/2) flavour of the XY route stage.
module router_sta_4port
    import router_sta_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] router_add,
    input  logic [ADDR_W-1:0] dst,
    output logic [2:0]        port
);

    router_sta #(.NUM_PORTS(4)) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .router_add (router_add),
        .dst        (dst),
        .port       (port)
    );

endmodule

// File: rtl/router_sta_xy_calc.sv
// Combinational XY direction decision: X is resolved before Y, and equal addresses mean LOCAL.
module router_sta_xy_calc
    import router_sta_pkg::*;
(
    input  logic [ADDR_W-1:0] router_add,
    input  logic [ADDR_W-1:0] dst,
    output port_t             dir
);

    logic [1:0] own_x;
    logic [1:0] dst_x;

    assign own_x = router_add[X_MSB:X_LSB];
    assign dst_x = dst[X_MSB:X_LSB];

    always_comb begin
        // NOTE: dir gets a default before any branch so no path leaves it unassigned (no latch).
        dir = PORT_LOCAL;
        if (dst_x > own_x)
            dir = PORT_EAST;
        else if (dst_x < own_x)
            dir = PORT_WEST;
        else if (dst[Y_BIT] != router_add[Y_BIT])
            dir = PORT_VERT;
    end

endmodule

// File: rtl/router_sta.sv
// Registered XY route stage shared by 3-port corner and 4-port middle routers.
// Optional positional legality check enabled by defining ROUTER_STA_CHECK_EN.
module router_sta
    import router_sta_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ADDR_W-1:0] router_add,
    input  logic [ADDR_W-1:0] dst,
    output logic [2:0]        port
);

    generate
        if (NUM_PORTS != 3 && NUM_PORTS != 4) begin : g_bad_num_ports
            $error("router_sta: NUM_PORTS must be 3 or 4");
        end
    endgenerate

    port_t raw_dir;
    port_t next_port;

    router_sta_xy_calc u_xy_calc (
        .router_add (router_add),
        .dst        (dst),
        .dir        (raw_dir)
    );

`ifdef ROUTER_STA_CHECK_EN
    assign next_port = port_exists(NUM_PORTS, router_add[X_MSB:X_LSB], raw_dir)
                       ? raw_dir : PORT_NONE;
`else
    assign next_port = raw_dir;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n)
            port <= PORT_NONE;
        else if (en)
            port <= next_port;
    end

endmodule

// File: tb/tb_router_sta.sv
// Self-checking bench for both router_sta flavours against an XY reference model and scoreboard.
module tb_router_sta;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] router_add;
    logic [2:0] dst;
    logic [2:0] port3;
    logic [2:0] port4;

    int tests;
    int fails;

    logic [2:0] q3[$];
    logic [2:0] q4[$];

    router_sta #(.NUM_PORTS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .router_add(router_add), .dst(dst), .port(port3)
    );

    router_sta #(.NUM_PORTS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .router_add(router_add), .dst(dst), .port(port4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] model(input int np, input logic [2:0] ra, input logic [2:0] d);
        logic [2:0] r;
        logic [1:0] ox;
        logic [1:0] dx;
        ox = ra[1:0];
        dx = d[1:0];
        if (dx > ox)            r = 3'd1;
        else if (dx < ox)       r = 3'd2;
        else if (d[2] != ra[2]) r = 3'd3;
        else                    r = 3'd0;
`ifdef ROUTER_STA_CHECK_EN
        if (np == 3 && (ox == 2'd1 || ox == 2'd2)) r = 3'd7;
        if (np == 4 && (ox == 2'd0 || ox == 2'd3)) r = 3'd7;
        if (r == 3'd1 && ox == 2'd3) r = 3'd7;
        if (r == 3'd2 && ox == 2'd0) r = 3'd7;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Compare both DUTs against the oldest scoreboard entries.
    task automatic check_sb(input string tag);
        logic [2:0] e3;
        logic [2:0] e4;
        if (q3.size() == 0 || q4.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e3 = q3.pop_front();
            e4 = q4.pop_front();
            check({tag, "/3p"}, port3, e3);
            check({tag, "/4p"}, port4, e4);
        end
    endtask

    task automatic step(input logic [2:0] ra, input logic [2:0] d, input string tag);
        @(negedge clk);
        router_add = ra;
        dst        = d;
        en         = 1'b1;
        q3.push_back(model(3, ra, d));
        q4.push_back(model(4, ra, d));
        @(posedge clk);
        #1;
        check_sb(tag);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        rst_n      = 1'b0;
        en         = 1'b0;
        router_add = 3'b000;
        dst        = 3'b000;

        repeat (2) @(posedge clk);
        #1;
        check("reset3", port3, 3'b111);
        check("reset4", port4, 3'b111);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_en0_3", port3, 3'b111);
        check("rel_en0_4", port4, 3'b111);

        step(3'b000, 3'b000, "first_load");

        // Corner router at column 0, row 0
        step(3'b000, 3'b011, "c0_east");
        step(3'b000, 3'b100, "c0_vert");
        step(3'b000, 3'b111, "c0_x_first");

        // Middle router at column 1, row 1
        step(3'b101, 3'b100, "m_west");
        step(3'b101, 3'b010, "m_east");
        step(3'b101, 3'b001, "m_vert");
        step(3'b101, 3'b101, "m_local");

        // Hold while en is low, then update on the next enabled edge
        step(3'b001, 3'b000, "hold_load");
        @(negedge clk);
        en  = 1'b0;
        dst = 3'b011;
        repeat (3) @(posedge clk);
        #1;
        check("hold3", port3, model(3, 3'b001, 3'b000));
        check("hold4", port4, model(4, 3'b001, 3'b000));
        step(3'b001, 3'b011, "hold_resume");

        // Positions that only the legality check rejects
        step(3'b001, 3'b000, "chk_3p_col1");
        step(3'b011, 3'b000, "chk_4p_col3");

        // Full sweep with a mid-stream asynchronous reset
        for (int i = 0; i < 64; i++) begin
            step(i[5:3], i[2:0], "sweep");
            if (i == 32) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("midrst3", port3, 3'b111);
                check("midrst4", port4, 3'b111);
                @(negedge clk);
                en    = 1'b0;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                check("postrst3", port3, 3'b111);
                check("postrst4", port4, 3'b111);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
